// File: rtl/seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_mux_driver
// Description : Time-multiplexed driver for NUM_DIGITS 7-segment digits that
//               share one segment bus. A refresh counter rotates the digit
//               enables. Each digit period opens with a dead window in which
//               every digit is off, which prevents ghosting between digits.
//               The display value is captured once per frame, so a change on
//               the inputs can never tear a frame. Every output is registered.
//
// Ports       : clk         in   system clock
//               reset_n     in   asynchronous active-low reset
//               digits      in   hex nibble per digit, digit k = [4k+3:4k]
//               blank       in   1 = digit k dark
//               dp          in   1 = decimal point of digit k lit
//               segs        out  segment drive {g,f,e,d,c,b,a}
//               dp_out      out  decimal-point drive
//               digit_en    out  one-hot digit enable
//               digit_idx   out  index of the digit owning the current period
//               frame_start out  pulse in the first cycle of digit 0's period
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_mux_driver #(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int DEAD_CYCLES    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b0,
  localparam int c_idx_w       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              segs,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [c_idx_w-1:0]      digit_idx,
  output logic                    frame_start
);

  localparam int                    c_cnt_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [6:0]            c_seg_off  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  c_dp_off   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] c_en_off   = EN_ACTIVE_LOW ? '1 : '0;

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_mux_driver: NUM_DIGITS must be in 1..8");
  end
  if (DEAD_CYCLES < 0) begin : g_bad_dead_cycles
    $error("seg_mux_driver: DEAD_CYCLES must be >= 0");
  end
  if (REFRESH_DIV <= DEAD_CYCLES) begin : g_bad_refresh_div
    $error("seg_mux_driver: REFRESH_DIV must exceed DEAD_CYCLES");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic                    r_run;        // low until the first edge after reset
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [6:0]              r_segs;
  logic                    r_dp_out;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_start;

  // --------------------------------------------------------------------------
  // Next-state computation
  // --------------------------------------------------------------------------
  logic                    w_wrap;
  logic                    w_snap;
  logic [c_cnt_w-1:0]      w_cnt_nxt;
  logic [c_idx_w-1:0]      w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_sh_digits_nxt;
  logic [NUM_DIGITS-1:0]   w_sh_blank_nxt;
  logic [NUM_DIGITS-1:0]   w_sh_dp_nxt;

  // The first edge after reset release does not advance the counter. It only
  // loads the outputs for cnt=0/idx=0, so the first visible cycle already
  // carries frame_start.
  always_comb begin
    w_wrap = (r_cnt == c_cnt_last);
    w_snap = r_run && w_wrap && (r_idx == c_idx_last);
    if (!r_run) begin
      w_cnt_nxt = '0;
      w_idx_nxt = '0;
    end else if (w_wrap) begin
      w_cnt_nxt = '0;
      w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
    end else begin
      w_cnt_nxt = r_cnt + c_cnt_w'(1);
      w_idx_nxt = r_idx;
    end
    // The shadow copy is refreshed only at the last edge of a frame.
    if (w_snap) begin
      w_sh_digits_nxt = digits;
      w_sh_blank_nxt  = blank;
      w_sh_dp_nxt     = dp;
    end else begin
      w_sh_digits_nxt = r_sh_digits;
      w_sh_blank_nxt  = r_sh_blank;
      w_sh_dp_nxt     = r_sh_dp;
    end
  end

  // Dead-window decode for both the upcoming and the current counter value
  logic w_dead_nxt;
  logic w_dead_cur;

  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign w_dead_nxt = 1'b0;
    assign w_dead_cur = 1'b0;
  end else begin : g_dead
    localparam logic [c_cnt_w-1:0] c_dead = c_cnt_w'(DEAD_CYCLES);
    assign w_dead_nxt = (w_cnt_nxt < c_dead);
    assign w_dead_cur = (r_cnt < c_dead);
  end

  // --------------------------------------------------------------------------
  // Digit selection from the upcoming index and shadow
  // --------------------------------------------------------------------------
  logic [3:0]            w_nib;
  logic                  w_blank_sel;
  logic                  w_dp_sel;
  logic [NUM_DIGITS-1:0] w_en_act_nxt;

  always_comb begin
    w_nib        = 4'h0;
    w_blank_sel  = 1'b1;
    w_dp_sel     = 1'b0;
    w_en_act_nxt = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == c_idx_w'(k)) begin
        w_nib           = w_sh_digits_nxt[4*k +: 4];
        w_blank_sel     = w_sh_blank_nxt[k];
        w_dp_sel        = w_sh_dp_nxt[k];
        w_en_act_nxt[k] = ~w_dead_nxt;
      end
    end
  end

  // Hex to segment decode, active-high {g,f,e,d,c,b,a}
  logic [6:0] w_hex;

  always_comb begin
    w_hex = 7'b0000000;
    case (w_nib)
      4'h0: w_hex = 7'b0111111;
      4'h1: w_hex = 7'b0000110;
      4'h2: w_hex = 7'b1011011;
      4'h3: w_hex = 7'b1001111;
      4'h4: w_hex = 7'b1100110;
      4'h5: w_hex = 7'b1101101;
      4'h6: w_hex = 7'b1111101;
      4'h7: w_hex = 7'b0000111;
      4'h8: w_hex = 7'b1111111;
      4'h9: w_hex = 7'b1100111;
      4'hA: w_hex = 7'b1110111;
      4'hB: w_hex = 7'b1111100;
      4'hC: w_hex = 7'b0111001;
      4'hD: w_hex = 7'b1011110;
      4'hE: w_hex = 7'b1111001;
      4'hF: w_hex = 7'b1110001;
      default: w_hex = 7'b0000000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_run         <= 1'b0;
      r_sh_digits   <= '0;
      r_sh_blank    <= '1;
      r_sh_dp       <= '0;
      r_segs        <= c_seg_off;
      r_dp_out      <= c_dp_off;
      r_digit_en    <= c_en_off;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_run         <= 1'b1;
      r_sh_digits   <= w_sh_digits_nxt;
      r_sh_blank    <= w_sh_blank_nxt;
      r_sh_dp       <= w_sh_dp_nxt;
      r_frame_start <= (w_cnt_nxt == '0) && (w_idx_nxt == '0);
      r_digit_en    <= EN_ACTIVE_LOW ? ~w_en_act_nxt : w_en_act_nxt;
      // A blanked digit keeps its enable but drives dark segments.
      if (w_dead_nxt || w_blank_sel) begin
        r_segs   <= c_seg_off;
        r_dp_out <= c_dp_off;
      end else begin
        r_segs   <= SEG_ACTIVE_LOW ? ~w_hex : w_hex;
        r_dp_out <= SEG_ACTIVE_LOW ? ~w_dp_sel : w_dp_sel;
      end
    end
  end

  assign segs        = r_segs;
  assign dp_out      = r_dp_out;
  assign digit_en    = r_digit_en;
  assign digit_idx   = r_idx;
  assign frame_start = r_frame_start;

  // --------------------------------------------------------------------------
  // Invariants
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_en_act_cur;
  assign w_en_act_cur = EN_ACTIVE_LOW ? ~r_digit_en : r_digit_en;

  a_en_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(w_en_act_cur));

  a_no_en_in_dead: assert property (@(posedge clk) disable iff (!reset_n)
    w_dead_cur |-> (w_en_act_cur == '0));

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_mux_driver
// Description : Bench for seg_mux_driver. Two instances run side by side: a
//               two-digit common-anode build and a single-digit build with
//               active-low enables and a one-cycle refresh period. Expected
//               outputs come from a frame/period arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_mux_driver;

  logic clk;
  logic reset_n;

  // Instance A: 2 digits, 8-cycle period, 2 dead cycles
  logic [7:0] digits_a;
  logic [1:0] blank_a;
  logic [1:0] dp_a;
  logic [6:0] segs_a;
  logic       dp_out_a;
  logic [1:0] en_a;
  logic [0:0] idx_a;
  logic       fs_a;

  // Instance B: 1 digit, 1-cycle period, no dead time, inverted polarities
  logic [3:0] digits_b;
  logic [0:0] blank_b;
  logic [0:0] dp_b;
  logic [6:0] segs_b;
  logic       dp_out_b;
  logic [0:0] en_b;
  logic [0:0] idx_b;
  logic       fs_b;

  seg_mux_driver #(
    .NUM_DIGITS(2), .REFRESH_DIV(8), .DEAD_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .digits(digits_a), .blank(blank_a), .dp(dp_a),
    .segs(segs_a), .dp_out(dp_out_a), .digit_en(en_a), .digit_idx(idx_a),
    .frame_start(fs_a)
  );

  seg_mux_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(1), .DEAD_CYCLES(0),
    .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .digits(digits_b), .blank(blank_b), .dp(dp_b),
    .segs(segs_b), .dp_out(dp_out_b), .digit_en(en_b), .digit_idx(idx_b),
    .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] segs;
    logic       dp;
    logic [7:0] en;
    logic [2:0] idx;
    logic       fs;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_a   = 1'b1;

  // Segment patterns, active-high {g..a}
  logic [6:0] hex_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Model configuration per instance
  int p_nd   [2] = '{2, 1};
  int p_rd   [2] = '{8, 1};
  int p_dead [2] = '{2, 0};
  bit p_seg  [2] = '{1'b1, 1'b0};
  bit p_en   [2] = '{1'b0, 1'b1};

  // Model state: cycles since start of operation and the displayed frame value
  int          m_t   [2];
  bit          m_run [2] = '{1'b0, 1'b0};
  logic [31:0] m_dg  [2];
  logic [7:0]  m_bl  [2];
  logic [7:0]  m_dp  [2];
  logic [31:0] in_dg [2];
  logic [7:0]  in_bl [2];
  logic [7:0]  in_dp [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic exp_t model_out(input int nd, input int rd, input int dead,
                                     input bit seg_al, input bit en_al, input int t,
                                     input logic [31:0] dg, input logic [7:0] bl,
                                     input logic [7:0] dpv);
    exp_t       e;
    int         d;
    int         ph;
    logic [7:0] mask;
    ph     = t % rd;
    d      = (t / rd) % nd;
    mask   = 8'((1 << nd) - 1);
    e.fs   = ((t % (nd * rd)) == 0);
    e.idx  = 3'(d);
    e.en   = '0;
    e.segs = '0;
    e.dp   = 1'b0;
    if (ph >= dead) begin
      e.en = 8'(1 << d);
      if (!bl[d]) begin
        e.segs = hex_tab[dg[4*d +: 4]];
        e.dp   = dpv[d];
      end
    end
    if (seg_al) begin
      e.segs = ~e.segs;
      e.dp   = ~e.dp;
    end
    if (en_al) e.en = ~e.en & mask;
    return e;
  endfunction

  // Stimulus and prediction: inputs change on the falling edge, and the
  // expected outputs after the following rising edge are queued.
  always @(negedge clk) begin
    exp_t e;
    if (rand_a) begin
      digits_a = 8'($urandom);
      blank_a  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      dp_a     = 2'($urandom);
    end
    digits_b = 4'($urandom);
    blank_b  = 1'($urandom_range(0, 7) == 0);
    dp_b     = 1'($urandom);
    in_dg[0] = 32'(digits_a);
    in_bl[0] = 8'(blank_a);
    in_dp[0] = 8'(dp_a);
    in_dg[1] = 32'(digits_b);
    in_bl[1] = 8'(blank_b);
    in_dp[1] = 8'(dp_b);
    for (int u = 0; u < 2; u++) begin
      if (!reset_n) begin
        m_run[u] = 1'b0;
        m_t[u]   = 0;
        m_dg[u]  = '0;
        m_bl[u]  = '1;
        m_dp[u]  = '0;
      end else begin
        if (!m_run[u]) begin
          m_run[u] = 1'b1;
          m_t[u]   = 0;
        end else begin
          if ((m_t[u] % (p_nd[u] * p_rd[u])) == p_nd[u] * p_rd[u] - 1) begin
            m_dg[u] = in_dg[u];
            m_bl[u] = in_bl[u];
            m_dp[u] = in_dp[u];
          end
          m_t[u]++;
        end
        e = model_out(p_nd[u], p_rd[u], p_dead[u], p_seg[u], p_en[u], m_t[u],
                      m_dg[u], m_bl[u], m_dp[u]);
        if (u == 0) qa.push_back(e);
        else        qb.push_back(e);
      end
    end
  end

  // Monitor: compare whatever the DUTs present against queued expectations
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      check("a_segs",  32'(segs_a),   32'(ea.segs));
      check("a_dp",    32'(dp_out_a), 32'(ea.dp));
      check("a_en",    32'(en_a),     32'(ea.en[1:0]));
      check("a_idx",   32'(idx_a),    32'(ea.idx));
      check("a_frame", 32'(fs_a),     32'(ea.fs));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      check("b_segs",  32'(segs_b),   32'(eb.segs));
      check("b_dp",    32'(dp_out_b), 32'(eb.dp));
      check("b_en",    32'(en_b),     32'(eb.en[0]));
      check("b_idx",   32'(idx_b),    32'(eb.idx));
      check("b_frame", 32'(fs_b),     32'(eb.fs));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_segs"},  32'(segs_a),   32'h7F);
    check({tag, "_a_dp"},    32'(dp_out_a), 32'h1);
    check({tag, "_a_en"},    32'(en_a),     32'h0);
    check({tag, "_a_idx"},   32'(idx_a),    32'h0);
    check({tag, "_a_frame"}, 32'(fs_a),     32'h0);
    check({tag, "_b_segs"},  32'(segs_b),   32'h00);
    check({tag, "_b_dp"},    32'(dp_out_b), 32'h0);
    check({tag, "_b_en"},    32'(en_b),     32'h1);
    check({tag, "_b_frame"}, 32'(fs_b),     32'h0);
  endtask

  // Returns 3 time units after the rising edge that puts instance A at the
  // requested position within its 16-cycle frame.
  task automatic wait_phase(input int ph, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #3;
      if (m_run[0] && (m_t[0] % 16) == ph) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL %s: frame position %0d not reached", tag, ph);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    digits_a = 8'($urandom);
    blank_a  = 2'($urandom);
    dp_a     = 2'($urandom);
    digits_b = 4'($urandom);
    blank_b  = 1'($urandom);
    dp_b     = 1'($urandom);

    // Reset held with random inputs
    repeat (3) @(posedge clk);
    #3;
    check_reset_vals("reset");

    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Steady 3A with dp on digit 1
    repeat (10) @(posedge clk);
    #2;
    rand_a   = 1'b0;
    digits_a = 8'h3A;
    blank_a  = 2'b00;
    dp_a     = 2'b10;
    repeat (48) @(posedge clk);

    // Update during digit 0 display; takes effect next frame
    wait_phase(3, "mid_frame_update");
    digits_a = 8'h55;
    repeat (40) @(posedge clk);

    // Blank digit 0
    #2;
    blank_a = 2'b01;
    repeat (40) @(posedge clk);

    // Random traffic
    rand_a = 1'b1;
    repeat (200) @(posedge clk);
    rand_a = 1'b0;

    // Reset in the middle of digit 1's display window (cnt=5, idx=1)
    wait_phase(13, "mid_reset");
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (3) @(posedge clk);
    #3;
    check_reset_vals("reset_hold");
    @(posedge clk);
    #2;
    reset_n  = 1'b1;
    digits_a = 8'hC7;
    blank_a  = 2'b00;
    dp_a     = 2'b01;
    repeat (60) @(posedge clk);

    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits that share one segment bus. It generalises the single-digit hex decoder with a refresh counter, rotating digit enables and per-digit blanking and decimal point. It also adds inter-digit dead time against ghosting and tear-free per-frame snapshotting of the display value. It sits between the keypad/value logic and the FPGA pins.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (legal 1..8)
REFRESH_DIV, 24000, clock cycles per digit period (legal >= DEAD_CYCLES+1)
DEAD_CYCLES, 16, cycles at start of each digit period with all digits disabled (legal >= 0)
SEG_ACTIVE_LOW, 1, 1: segment/dp outputs driven low to light (common anode); 0: active-high
EN_ACTIVE_LOW, 0, 1: digit enables active-low; 0: active-high

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
digits  in  4*NUM_DIGITS  hex nibble per digit; digit k = digits[4k+3:4k]
blank  in  NUM_DIGITS  1 = digit k dark
dp  in  NUM_DIGITS  1 = decimal point of digit k lit
segs  out  7  segment drive {g,f,e,d,c,b,a}, bit0 = a, polarity per SEG_ACTIVE_LOW
dp_out  out  1  decimal-point drive, polarity per SEG_ACTIVE_LOW
digit_en  out  NUM_DIGITS  one-hot digit enable, polarity per EN_ACTIVE_LOW
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of digit owning current period
frame_start  out  1  one-cycle pulse at first cycle of digit 0's period

Behaviour:
- Async reset (reset_n low): cnt=0, idx=0, shadow digits=0, shadow blank=all 1s, shadow dp=0; segs/dp_out at inactive level; digit_en all inactive; digit_idx=0; frame_start=0.
- cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, idx increments modulo NUM_DIGITS; NUM_DIGITS=1 keeps idx=0.
- Phase per period: DEAD while cnt < DEAD_CYCLES, SHOW otherwise. DEAD_CYCLES=0 means always SHOW.
- Snapshot: on the edge where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1, shadow <= {digits, blank, dp}. Input changes inside a frame become visible only from the next frame. The first frame after reset is fully blank.
- All outputs are registered and computed from next-state (cnt, idx, shadow), so they change on the same edge as the counter. Sampled in any cycle, outputs reflect that cycle's cnt and idx.
- In DEAD: digit_en all inactive; segs and dp_out inactive.
- In SHOW: digit_en[idx] active, others inactive. If shadow blank[idx] is 1, segs and dp_out are inactive and digit_en stays active. Otherwise segs = hex pattern of shadow nibble[idx] and dp_out = shadow dp[idx].
- Hex patterns, active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. With SEG_ACTIVE_LOW=1 the bitwise inverse is driven.
- frame_start=1 exactly in cycles where cnt=0 and idx=0, including the first cycle after reset release. Period is NUM_DIGITS*REFRESH_DIV cycles.
- digit_idx = idx.
- Invariants, checked by assertion: at most one digit_en active at any time; no digit enabled during DEAD.
- Reset asserted mid-period: all outputs go inactive immediately (asynchronously). Operation restarts at cnt=0, idx=0 with a blank frame.
- Illegal parameters (REFRESH_DIV <= DEAD_CYCLES, NUM_DIGITS = 0 or > 8) are rejected with an elaboration-time error.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> segs=7'h7F, dp_out=1, digit_en=2'b00 (defaults). Release -> frame_start=1 in the first cycle; the first frame is dark.
- NUM_DIGITS=2, REFRESH_DIV=8, DEAD_CYCLES=2, digits=8'h3A, blank=0, dp=2'b10, steady -> from the second frame:
  - digit 0: cycles 0-1 dark, cycles 2-7 digit_en=01, segs=~7'b1110111 (A), dp_out=1.
  - digit 1: same timing, digit_en=10, segs=~7'b1001111 (3), dp_out=0.
- Mid-frame update: change digits from 8'h3A to 8'h55 during digit 0 SHOW -> the rest of the frame still shows A/3; the next frame shows 5/5.
- Blank: blank=2'b01 -> digit 0 periods have digit_en=01 and segs=7'h7F; digit 1 is unaffected.
- Reset mid-operation: assert reset_n=0 at cnt=5, idx=1 -> outputs go inactive before the next clk edge. After release, digit_idx=0, frame_start=1, and one blank frame follows.
- Edge parameters: NUM_DIGITS=1, DEAD_CYCLES=0, REFRESH_DIV=1, SEG_ACTIVE_LOW=0, EN_ACTIVE_LOW=1 -> digit_en=0 continuously from the second cycle and frame_start=1 every cycle. Active-high segs track the digits input with a one-cycle delay (snapshot every cycle), e.g. digits=4'h0 -> segs=7'b0111111.
